// File: rtl/stopwatch_counter.sv
// stopwatch_counter: mm:ss stopwatch with run/pause, synchronous clear and 2-speed field adjust
// Ports: clk, rst_n (async, active-low); pause_p toggles paused; clr zeroes fields and prescalers;
// adj selects adjust mode, sel picks seconds (1) or minutes (0); seccounter/mincounter registered
// fields; paused state; tick_1hz/tick_adj prescaler strobes; wrap marks the 59:59 -> 00:00 rollover.
module stopwatch_counter #(
  parameter int DIV_1HZ = 100000000,
  parameter int DIV_ADJ = 50000000,
  parameter int CNT_W   = 6,
  parameter int SEC_MOD = 60,
  parameter int MIN_MOD = 60
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pause_p,
  input  logic             clr,
  input  logic             adj,
  input  logic             sel,
  output logic [CNT_W-1:0] seccounter,
  output logic [CNT_W-1:0] mincounter,
  output logic             paused,
  output logic             tick_1hz,
  output logic             tick_adj,
  output logic             wrap
);
  localparam int P1_W = $clog2(DIV_1HZ);
  localparam int PA_W = $clog2(DIV_ADJ);
  logic [P1_W-1:0]  pre1, pre1_n;
  logic [PA_W-1:0]  prea, prea_n;
  logic [CNT_W-1:0] sec_n, min_n, sec_inc, min_inc;
  logic             sec_max, min_max, run, adj_step, wrap_n;
  // Strobes decode the prescaler state directly so a field moves on the edge that sees them.
  assign tick_1hz = pre1 == P1_W'(DIV_1HZ - 1);
  assign tick_adj = prea == PA_W'(DIV_ADJ - 1);
  always_comb begin
    sec_max  = seccounter == CNT_W'(SEC_MOD - 1);
    min_max  = mincounter == CNT_W'(MIN_MOD - 1);
    sec_inc  = sec_max ? '0 : seccounter + 1'b1;
    min_inc  = min_max ? '0 : mincounter + 1'b1;
    run      = tick_1hz & ~paused & ~adj;
    adj_step = tick_adj & adj;
    sec_n    = clr ? '0 : adj_step ? (sel ? sec_inc : seccounter) : run ? sec_inc : seccounter;
    min_n    = clr ? '0 : adj_step ? (sel ? mincounter : min_inc) : (run & sec_max) ? min_inc : mincounter;
    // Only a carried run step out of the last second of the last minute is a rollover.
    wrap_n   = ~clr & ~adj_step & run & sec_max & min_max;
    pre1_n   = (clr | tick_1hz) ? '0 : pre1 + 1'b1;
    prea_n   = (clr | ~adj | tick_adj) ? '0 : prea + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      seccounter <= '0;
      mincounter <= '0;
      paused     <= 1'b0;
      wrap       <= 1'b0;
      pre1       <= '0;
      prea       <= '0;
    end else begin
      seccounter <= sec_n;
      mincounter <= min_n;
      paused     <= paused ^ pause_p;
      wrap       <= wrap_n;
      pre1       <= pre1_n;
      prea       <= prea_n;
    end
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: directed scenarios plus random stimulus against a time-arithmetic model
module tb_stopwatch_counter;
  localparam int D1 = 4, DA = 2, SM = 60, MM = 60;
  logic clk = 0, rst_n = 0, pause_p = 0, clr = 0, adj = 0, sel = 0;
  logic [5:0] seccounter, mincounter;
  logic paused, tick_1hz, tick_adj, wrap;
  int checks = 0, failures = 0;
  int m_sec, m_min, m_cyc1, m_cyca, tot;
  bit m_paused, m_wrap, t1, ta;
  stopwatch_counter #(.DIV_1HZ(D1), .DIV_ADJ(DA)) dut (
    .clk(clk), .rst_n(rst_n), .pause_p(pause_p), .clr(clr), .adj(adj), .sel(sel),
    .seccounter(seccounter), .mincounter(mincounter), .paused(paused),
    .tick_1hz(tick_1hz), .tick_adj(tick_adj), .wrap(wrap));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: time held as total seconds, prescalers as cycles elapsed since their last restart.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_sec = 0; m_min = 0; m_cyc1 = 0; m_cyca = 0; m_paused = 0; m_wrap = 0;
    end else begin
      t1 = (m_cyc1 == D1 - 1);
      ta = (m_cyca == DA - 1);
      m_wrap = 0;
      if (clr) begin
        m_sec = 0; m_min = 0;
      end else if (ta && adj) begin
        if (sel) m_sec = (m_sec + 1) % SM;
        else m_min = (m_min + 1) % MM;
      end else if (t1 && !m_paused && !adj) begin
        tot = (m_min * SM + m_sec + 1) % (SM * MM);
        m_sec = tot % SM;
        m_min = tot / SM;
        m_wrap = (tot == 0);
      end
      if (pause_p) m_paused = !m_paused;
      m_cyc1 = clr ? 0 : (m_cyc1 + 1) % D1;
      m_cyca = (clr || !adj) ? 0 : (m_cyca + 1) % DA;
    end
  always @(negedge clk)
    if (rst_n) begin
      chk("sec", seccounter, m_sec);
      chk("min", mincounter, m_min);
      chk("paused", paused, m_paused);
      chk("tick_1hz", tick_1hz, m_cyc1 == D1 - 1);
      chk("tick_adj", tick_adj, m_cyca == DA - 1);
      chk("wrap", wrap, m_wrap);
    end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_field(input bit is_sec, input int v, input string nm);
    int n = 0;
    while (int'(is_sec ? seccounter : mincounter) != v && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n < 300, 1);
  endtask
  task automatic wait_tick(input string nm);
    int n = 0;
    while (!tick_1hz && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n < 10, 1);
  endtask
  task automatic pulse_pause;
    pause_p = 1;
    cyc(1);
    pause_p = 0;
  endtask
  task automatic zeros(input string nm);
    chk(nm, {seccounter, mincounter, paused, tick_1hz, tick_adj, wrap}, 0);
  endtask
  initial begin
    cyc(2);
    zeros("reset_state");
    rst_n = 1;
    cyc(236);
    chk("run_sec59", seccounter, 59);
    chk("run_min0", mincounter, 0);
    cyc(4);
    chk("run_sec0", seccounter, 0);
    chk("run_min1", mincounter, 1);
    adj = 1; sel = 0;
    wait_field(0, 59, "adj_min59_to");
    sel = 1;
    wait_field(1, 59, "adj_sec59_to");
    adj = 0;
    wait_tick("wrap_tick_to");
    cyc(1);
    chk("wrap_sec", seccounter, 0);
    chk("wrap_min", mincounter, 0);
    chk("wrap_hi", wrap, 1);
    cyc(1);
    chk("wrap_lo", wrap, 0);
    clr = 1;
    cyc(1);
    clr = 0;
    wait_field(1, 10, "sec10_to");
    pulse_pause();
    cyc(40);
    chk("pause_sec", seccounter, 10);
    chk("pause_min", mincounter, 0);
    chk("pause_on", paused, 1);
    pulse_pause();
    wait_field(1, 11, "resume_to");
    chk("pause_off", paused, 0);
    adj = 1; sel = 0;
    wait_field(0, 3, "min3_to");
    sel = 1;
    wait_field(1, 59, "sec59_to");
    cyc(1);
    while (seccounter == 59) cyc(1);
    chk("adjwrap_sec", seccounter, 0);
    chk("adjwrap_min", mincounter, 3);
    chk("adjwrap_wrap", wrap, 0);
    adj = 0;
    pulse_pause();
    adj = 1; sel = 0;
    wait_field(0, 12, "min12_to");
    sel = 1;
    wait_field(1, 34, "sec34_to");
    adj = 0;
    wait_tick("align_to");
    cyc(3);
    adj = 1;
    cyc(1);
    chk("co_tick1", tick_1hz, 1);
    chk("co_ticka", tick_adj, 1);
    chk("co_sec", seccounter, 34);
    chk("co_min", mincounter, 12);
    clr = 1;
    cyc(1);
    clr = 0; adj = 0;
    chk("clr_sec", seccounter, 0);
    chk("clr_min", mincounter, 0);
    chk("clr_paused", paused, 1);
    chk("clr_tick_lo", tick_1hz, 0);
    cyc(3);
    chk("clr_tick_hi", tick_1hz, 1);
    pulse_pause();
    adj = 1; sel = 0;
    wait_field(0, 5, "min5_to");
    sel = 1;
    wait_field(1, 7, "sec7_to");
    adj = 0;
    #2 rst_n = 0;
    #1 zeros("async_reset");
    @(negedge clk);
    rst_n = 1;
    cyc(3);
    chk("rel_tick", tick_1hz, 1);
    chk("rel_sec", seccounter, 0);
    for (int i = 0; i < 3000; i++) begin
      pause_p = ($urandom % 20 == 0);
      clr = ($urandom % 150 == 0);
      if ($urandom % 40 == 0) adj = !adj;
      if ($urandom % 8 == 0) sel = $urandom % 2;
      cyc(1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
